// File: rtl/cram_cfg_loader_if.sv
// Bitstream word handshake between the SoC-side source (master) and the CRAM loader (slave).
interface cram_cfg_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/cram_cfg_loader.sv
// Serialises bitstream words LSB-first into the fabric CRAM chain, stopping after CHAIN_LEN bits.
// Optional CRC-16-CCITT of the transmitted bits when CFG_LOADER_CRC_EN is defined.
module cram_cfg_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 4096,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic                    abort,
  cram_cfg_loader_if.slave        wbus,
  output logic                    cfg_en,
  output logic                    cfg_data,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             crc
);
  localparam int unsigned WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_shreg;
  logic [WB_W-1:0]   r_wbits;
  logic [WB_W-1:0]   w_wbits_load;
  logic [CNT_W-1:0]  r_sent;
  logic [CNT_W-1:0]  w_sent_base;
  logic [CNT_W-1:0]  w_rem;
  logic              w_last_bit;
  logic              w_last_chain;
  logic              w_ready;
  logic              w_load;
  logic              w_start_ok;

  assign w_last_bit   = (r_wbits == WB_W'(1));
  assign w_last_chain = (r_sent == CNT_W'(CHAIN_LEN - 1));
  assign w_start_ok   = (r_state == S_IDLE) && start && !abort;

  // A reload on the last bit of a word must account for the bit leaving this cycle.
  assign w_sent_base  = (r_state == S_SHIFT) ? (r_sent + CNT_W'(1)) : r_sent;
  assign w_rem        = CNT_W'(CHAIN_LEN) - w_sent_base;
  assign w_wbits_load = (32'(w_rem) >= WORD_W) ? WB_W'(WORD_W) : WB_W'(w_rem);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_ready = 1'b1;
        if (abort)                 w_state_nxt = S_IDLE;
        else if (wbus.word_valid)  w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_ready = w_last_bit && !w_last_chain;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last_bit) begin
          if (w_last_chain)          w_state_nxt = S_DONE;
          else if (!wbus.word_valid) w_state_nxt = S_FETCH;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign wbus.word_ready = w_ready;
  assign w_load          = wbus.word_valid && w_ready && !abort;

  assign cfg_en   = (r_state == S_SHIFT);
  assign cfg_data = cfg_en & r_shreg[0];
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_shreg <= '0;
      r_wbits <= '0;
      r_sent  <= '0;
    end else begin
      if (w_start_ok) r_sent <= '0;
      if (r_state == S_SHIFT) begin
        r_shreg <= r_shreg >> 1;
        r_wbits <= r_wbits - WB_W'(1);
        r_sent  <= r_sent + CNT_W'(1);
      end
      if (w_load) begin
        r_shreg <= wbus.word_data;
        r_wbits <= w_wbits_load;
      end
    end
  end

`ifdef CFG_LOADER_CRC_EN
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ r_shreg[0];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_crc <= '0;
    end else if (w_start_ok) begin
      r_crc <= '1;
    end else if (r_state == S_SHIFT) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign crc = r_crc;
`else
  assign crc = '0;
`endif

endmodule
